seq_chunk_adder: RTL and testbench
==================================

SEQ_CHUNK_ADDER -- requirements
Module: seq_chunk_adder

Interface
REQ-001 The block SHALL have parameter WIDTH, default 16: operand and sum width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 4: bits added per clock cycle; WIDTH SHALL be an integer multiple of CHUNK, and NCHUNK = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have port in_valid, input, 1 bit: operands a, b, cin, sub are valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have port a, input, WIDTH bits: first operand.
REQ-008 The block SHALL have port b, input, WIDTH bits: second operand.
REQ-009 The block SHALL have port cin, input, 1 bit: carry-in; ignored when sub=1.
REQ-010 The block SHALL have port sub, input, 1 bit: mode select; 0 computes a+b+cin, 1 computes a-b as a+~b+1.
REQ-011 The block SHALL have port out_valid, output, 1 bit: sum, cout and ovf are valid.
REQ-012 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-013 The block SHALL have port sum, output, WIDTH bits: result modulo 2^WIDTH.
REQ-014 The block SHALL have port cout, output, 1 bit: carry out of bit WIDTH-1; in sub mode 1 means no borrow.
REQ-015 The block SHALL have port ovf, output, 1 bit: two's-complement signed overflow.

Function
REQ-016 The FSM SHALL have exactly three states, IDLE, CALC and DONE.
REQ-017 in_ready SHALL be 1 only in IDLE, and out_valid SHALL be 1 only in DONE.
REQ-018 An input handshake SHALL occur on a rising edge with in_valid=1 in IDLE; a, b (or ~b when sub=1) and the carry (cin, or 1 when sub=1) SHALL be captured in that edge, the chunk counter cleared, and the state moved to CALC.
REQ-019 In CALC, each edge SHALL add operand chunk [i*CHUNK +: CHUNK] plus the carry register, write the chunk result into sum[i*CHUNK +: CHUNK], update the carry register, and increment i, starting from the LSB chunk.
REQ-020 When i = NCHUNK-1 the CALC edge SHALL also register cout (the final carry) and ovf (carry into the MSB XOR carry out of the MSB), and move to DONE.
REQ-021 out_valid SHALL rise exactly NCHUNK edges after the accepting edge.
REQ-022 In DONE, sum, cout and ovf SHALL stay stable until an edge with out_ready=1, which SHALL move to IDLE.
REQ-023 Back-to-back operation SHALL give a minimum initiation interval of NCHUNK+2 cycles.
REQ-024 Input changes during CALC or DONE SHALL have no effect on the operation in progress.
REQ-025 in_valid held high while in_ready=0 SHALL NOT start a second operation until the block returns to IDLE.
REQ-026 When CHUNK = WIDTH, the block SHALL be a 1-cycle CALC with identical results.

Reset
REQ-027 On an edge with rst_n=0, the state SHALL go to IDLE and the counter, carry register, sum, cout and ovf SHALL be cleared to 0.
REQ-028 Under reset, in_ready SHALL be 1 after the reset edge and out_valid SHALL be 0.
REQ-029 Reset asserted during CALC or DONE SHALL abort the operation without producing out_valid.
REQ-030 An in_valid present in the same edge as rst_n=0 SHALL be ignored.

Structure
REQ-031 A shared package SHALL hold the state enumeration (IDLE, CALC, DONE) and the default WIDTH/CHUNK constants.
REQ-032 The chunk addition SHALL be one combinational sub-module, rca_chunk, parameterised by CHUNK, with ports x, y, ci, s and co, and also exposing carry into its MSB for ovf.
REQ-033 A WIDTH not divisible by CHUNK SHALL be rejected by an elaboration-time check.

Verification (WIDTH=16, CHUNK=4)
REQ-034 The bench SHALL drive a=0x0006, b=0x0007, cin=1, sub=0 and require sum=0x000E, cout=0, ovf=0, with out_valid exactly 4 edges after acceptance.
REQ-035 The bench SHALL drive a=0xFFFF, b=0x0001, cin=0, sub=0 and require sum=0x0000, cout=1, ovf=0; and a=0x7FFF, b=0x0001, cin=0 and require sum=0x8000, cout=0, ovf=1.
REQ-036 The bench SHALL drive sub=1 with a=0x0003, b=0x0005 (cin=1, to check it is ignored) and require sum=0xFFFE, cout=0, ovf=0; and a=0x8000, b=0x0001 and require sum=0x7FFF, cout=1, ovf=1.
REQ-037 The bench SHALL hold out_ready=0 for 5 cycles in DONE and require out_valid, sum and cout to stay stable and in_ready=0 with in_valid held high; then out_ready=1 for one edge and require IDLE and in_ready=1.
REQ-038 The bench SHALL assert rst_n=0 for one edge at CALC chunk 2, then release, and require out_valid never rises for the aborted operation and sum=0x0000; a following operation a=0x1234, b=0x4321 SHALL give 0x5555.
REQ-039 The bench SHALL change a and b mid-CALC and require the result to reflect the captured operands only.

Source files
------------

// File: rtl/seq_chunk_adder_pkg.sv
// Shared types and default sizing for the chunk-serial adder.
//   state_t   : controller states (IDLE, CALC, DONE)
//   DEF_WIDTH : default operand/sum width
//   DEF_CHUNK : default bits added per cycle
package seq_chunk_adder_pkg;

  localparam int unsigned DEF_WIDTH = 16;
  localparam int unsigned DEF_CHUNK = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage : seq_chunk_adder_pkg

// File: rtl/seq_chunk_adder_rca_chunk.sv
// Combinational CHUNK-bit adder slice.
//   x, y  : chunk operands
//   ci    : carry into bit 0
//   s     : chunk sum
//   co    : carry out of the chunk MSB
//   c_msb : carry into the chunk MSB (used for signed overflow)
module rca_chunk #(
  parameter int unsigned CHUNK = 4
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb
);

  localparam int unsigned TW = CHUNK + 1;

  logic [CHUNK:0] total;

  assign total = {1'b0, x} + {1'b0, y} + TW'(ci);
  assign s     = total[CHUNK-1:0];
  assign co    = total[CHUNK];
  // Sum bit = x ^ y ^ carry-in, so the carry into the MSB falls out of the XOR.
  assign c_msb = x[CHUNK-1] ^ y[CHUNK-1] ^ s[CHUNK-1];

endmodule : rca_chunk

// File: rtl/seq_chunk_adder.sv
// Chunk-serial adder/subtractor: adds CHUNK bits per clock, LSB chunk first.
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid, in_ready  : operand handshake (ready only in IDLE)
//   a, b, cin, sub      : operands; sub=1 computes a-b as a+~b+1 (cin ignored)
//   out_valid, out_ready: result handshake (valid only in DONE)
//   sum, cout, ovf      : result, carry out (no-borrow in sub mode), signed overflow
module seq_chunk_adder
  import seq_chunk_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH,
  parameter int unsigned CHUNK = DEF_CHUNK
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  // Reject widths that do not split into whole chunks.
  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             carry;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;

  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co;
  logic             chunk_cm;

  // Operands are shifted right each cycle so the active chunk is always at bit 0.
  rca_chunk #(
    .CHUNK (CHUNK)
  ) u_rca (
    .x     (op_a[CHUNK-1:0]),
    .y     (op_b[CHUNK-1:0]),
    .ci    (carry),
    .s     (chunk_s),
    .co    (chunk_co),
    .c_msb (chunk_cm)
  );

  // Controller and datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            op_a     <= a;
            op_b     <= sub ? ~b : b;
            carry    <= sub ? 1'b1 : cin;
            cnt      <= '0;
            in_ready <= 1'b0;
            state    <= CALC;
          end
        end

        CALC: begin
          for (int unsigned k = 0; k < NCHUNK; k++) begin
            if (cnt == CNT_W'(k)) begin
              sum[k*CHUNK +: CHUNK] <= chunk_s;
            end
          end
          carry <= chunk_co;
          op_a  <= op_a >> CHUNK;
          op_b  <= op_b >> CHUNK;
          if (cnt == CNT_W'(NCHUNK - 1)) begin
            cout      <= chunk_co;
            ovf       <= chunk_cm ^ chunk_co;
            out_valid <= 1'b1;
            state     <= DONE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end

        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule : seq_chunk_adder

// File: tb/tb_seq_chunk_adder.sv
// Self-checking bench for seq_chunk_adder (WIDTH=16, CHUNK=4).
module tb_seq_chunk_adder;

  typedef struct packed {
    logic [15:0] sum;
    logic        cout;
    logic        ovf;
  } res_t;

  typedef struct packed {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic        sub;
    res_t        res;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int   tests  = 0;
  int   errors = 0;
  res_t sb_q[$];
  vec_t vecs[10];

  seq_chunk_adder #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // Reference: plain 17-bit addition, overflow from operand/result signs.
  function automatic res_t model(input logic [15:0] ma, input logic [15:0] mb,
                                 input logic mcin, input logic msub);
    logic [15:0] bb;
    logic [16:0] full;
    res_t r;
    bb     = msub ? ~mb : mb;
    full   = {1'b0, ma} + {1'b0, bb} + 17'(msub ? 1'b1 : mcin);
    r.sum  = full[15:0];
    r.cout = full[16];
    r.ovf  = (ma[15] == bb[15]) && (r.sum[15] != ma[15]);
    return r;
  endfunction

  // One full transaction; called and sampled at a negedge.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb, input logic tcin,
                        input logic tsub, input res_t exp, input bit scramble);
    int   n;
    res_t e;
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", 32'(in_ready), 32'd1);
    a = ta; b = tb; cin = tcin; sub = tsub; in_valid = 1'b1;
    sb_q.push_back(exp);
    @(negedge clk);
    chk("accepted", 32'(in_ready), 32'd0);
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin
      if (scramble) begin
        a = 16'($urandom); b = 16'($urandom);
        cin = 1'($urandom); sub = 1'($urandom); in_valid = 1'b1;
      end
      @(negedge clk);
      n++;
    end
    chk("latency", 32'(n), 32'd4);
    if (sb_q.size() == 0) begin
      chk("sb_nonempty", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("sum", 32'(sum), 32'(e.sum));
      chk("cout", 32'(cout), 32'(e.cout));
      chk("ovf", 32'(ovf), 32'(e.ovf));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("back_idle_ready", 32'(in_ready), 32'd1);
    chk("back_idle_valid", 32'(out_valid), 32'd0);
  endtask

  initial begin
    int   n;
    int   first;
    int   second;
    res_t e;

    vecs[0] = '{16'h0006, 16'h0007, 1'b1, 1'b0, '{16'h000E, 1'b0, 1'b0}};
    vecs[1] = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b0}};
    vecs[2] = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, '{16'h8000, 1'b0, 1'b1}};
    vecs[3] = '{16'h0003, 16'h0005, 1'b1, 1'b1, '{16'hFFFE, 1'b0, 1'b0}};
    vecs[4] = '{16'h8000, 16'h0001, 1'b0, 1'b1, '{16'h7FFF, 1'b1, 1'b1}};
    vecs[5] = '{16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0}};
    vecs[6] = '{16'h5555, 16'h5555, 1'b0, 1'b1, '{16'h0000, 1'b1, 1'b0}};
    vecs[7] = '{16'h8000, 16'h8000, 1'b0, 1'b0, '{16'h0000, 1'b1, 1'b1}};
    vecs[8] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, '{16'hFFFF, 1'b1, 1'b0}};
    vecs[9] = '{16'h0FFF, 16'h0001, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0}};

    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_sum", 32'(sum), 32'd0);
    chk("rst_cout", 32'(cout), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);

    // Directed vector table.
    for (int i = 0; i < 10; i++) begin
      run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub, vecs[i].res, 1'b0);
    end

    // Operands change mid-calculation; result must reflect captured values.
    run_op(16'h00FF, 16'h0F01, 1'b0, 1'b0, '{16'h1000, 1'b0, 1'b0}, 1'b1);

    // Random operations, some with scrambled inputs during CALC/DONE.
    for (int i = 0; i < 16; i++) begin
      logic [15:0] ra, rb;
      logic        rc, rs;
      ra = 16'($urandom); rb = 16'($urandom);
      rc = 1'($urandom);  rs = 1'($urandom);
      run_op(ra, rb, rc, rs, model(ra, rb, rc, rs), 1'(i % 2));
    end

    // Stall in DONE with in_valid held high.
    e = model(16'h1234, 16'h1111, 1'b0, 1'b0);
    a = 16'h1234; b = 16'h1111; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("stall_latency", 32'(n), 32'd4);
    for (int i = 0; i < 5; i++) begin
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_sum", 32'(sum), 32'(e.sum));
      chk("stall_cout", 32'(cout), 32'(e.cout));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
      @(negedge clk);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("stall_release_ready", 32'(in_ready), 32'd1);
    chk("stall_release_valid", 32'(out_valid), 32'd0);

    // Reset at CALC chunk 2, with in_valid present on the reset edge.
    a = 16'h1111; b = 16'h2222; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0; in_valid = 1'b1; a = 16'hFFFF; b = 16'hFFFF;
    @(negedge clk);
    rst_n = 1'b1; in_valid = 1'b0;
    chk("abort_in_ready", 32'(in_ready), 32'd1);
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_sum", 32'(sum), 32'd0);
    chk("abort_cout", 32'(cout), 32'd0);
    chk("abort_ovf", 32'(ovf), 32'd0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("abort_no_valid", 32'(out_valid), 32'd0);
    end
    run_op(16'h1234, 16'h4321, 1'b0, 1'b0, '{16'h5555, 1'b0, 1'b0}, 1'b0);

    // Back-to-back initiation interval with in_valid and out_ready held high.
    a = 16'h0101; b = 16'h0202; cin = 1'b0; sub = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    first = -1; second = -1;
    for (int c = 0; c < 20; c++) begin
      if (in_ready) begin
        if (first < 0) first = c;
        else if (second < 0) second = c;
      end
      if (out_valid) chk("ii_sum", 32'(sum), 32'h0303);
      @(negedge clk);
    end
    in_valid = 1'b0;
    chk("ii_interval", 32'(second - first), 32'd6);
    n = 0;
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    out_ready = 1'b0;
    chk("drain_idle", 32'(in_ready), 32'd1);
    chk("sb_empty", 32'(sb_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule : tb_seq_chunk_adder
